// File: rtl/rdoq_rate_pkg.sv
// Shared types for the RDOQ rate-calculator scheduler: calculator request
// payload, scheduler state encoding and the error rate value.
package rdoq_rate_pkg;

  typedef struct packed {
    logic [15:0] uiAbsLevel;
    logic [15:0] ui16AbsGoRice;
    logic        useLimitedPrefixLength;
    logic [4:0]  maxLog2TrDynamicRange;
    logic [7:0]  c1Idx;
    logic [7:0]  c2Idx;
    logic [4:0]  greaterOne_ctx_addr;
    logic [4:0]  levelAbs_ctx_addr;
    logic        read_bin_sel;
  } rc_req_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    FLUSH
  } sched_state_t;

  localparam logic [31:0] RATE_ERR = 32'hFFFF_FFFF;

endpackage

// File: rtl/rate_calc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!any && req[IW'(idx)]) begin
        any             = 1'b1;
        gnt[IW'(idx)]   = 1'b1;
        gnt_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rate_calc_scheduler.sv
// Shares one rate calculator between NUM_REQ requesters: round-robin grant,
// held payload, start pulse, done/watchdog wait and id-tagged response.
module rate_calc_scheduler
  import rdoq_rate_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  rc_req_t [NUM_REQ-1:0] req_payload,
  output logic                  calc_start,
  output rc_req_t               calc_req,
  input  logic                  calc_done,
  input  logic [31:0]           calc_rate,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_rate,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t      state;
  logic [ID_W-1:0]   rr_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic              late_done;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic [ID_W-1:0]   next_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Grant is masked while reset is asserted so no handshake can be lost in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE) req_ready = arb_gnt;
    next_ptr = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      late_done  <= 1'b0;
      calc_req   <= '0;
      calc_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rate   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            calc_req   <= req_payload[arb_idx];
            rsp_id     <= arb_idx;
            rr_ptr     <= next_ptr;
            calc_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (calc_done) begin
            rsp_rate  <= calc_rate;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_rate  <= RATE_ERR;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          // A hung calculator may still finish; remember it so FLUSH does not wait forever.
          if (calc_done && rsp_err) late_done <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_err) begin
              state <= FLUSH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (calc_done || late_done) begin
            late_done <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
